sum_tree_batch_arbiter: RTL and testbench

//  Shares one order-independent summing tree among NUM_REQ requesters, one batch of NUM_INPUTS

---
 rtl/sum_tree_batch_arbiter_pkg.sv | 16 +
 rtl/sum_tree_batch_arbiter_if.sv | 39 +++
 rtl/sum_tree_batch_arbiter_rr_arbiter.sv | 27 ++
 rtl/sum_tree_batch_arbiter.sv | 128 ++++++++++++
 tb/tb_sum_tree_batch_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_tree_batch_arbiter_pkg.sv
// Shared types and helpers for the summing-tree batch arbiter, its tree wrapper and bench.
package sum_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      WAIT_SUM,
      HOLD
   } state_t;

   // Sum width needed so that NUM_INPUTS full-scale words never overflow.
   function automatic int sum_w(input int dw, input int n);
      return dw + $clog2(n);
   endfunction

endpackage

// File: rtl/sum_tree_batch_arbiter_if.sv
// Client, tree and result signals of the batch arbiter; slave = arbiter side.
interface sum_tree_batch_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_INPUTS = 8,
   parameter int DATA_WIDTH = 32
);
   import sum_arb_pkg::*;

   localparam int SUM_W = sum_w(DATA_WIDTH, NUM_INPUTS);
   localparam int ID_W  = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          tree_valid;
   logic [DATA_WIDTH-1:0]         tree_data;
   logic                          tree_ready;
   logic [SUM_W-1:0]              tree_sum;
   logic                          tree_sum_valid;
   logic                          res_valid;
   logic                          res_ready;
   logic [SUM_W-1:0]              res_sum;
   logic [ID_W-1:0]               res_id;
   logic                          err_timeout;
   logic                          err_spurious;

   modport slave (
      input  req_valid, req_data, tree_ready, tree_sum, tree_sum_valid, res_ready,
      output req_ready, tree_valid, tree_data, res_valid, res_sum, res_id,
             err_timeout, err_spurious
   );

   modport master (
      output req_valid, req_data, tree_ready, tree_sum, tree_sum_valid, res_ready,
      input  req_ready, tree_valid, tree_data, res_valid, res_sum, res_id,
             err_timeout, err_spurious
   );

endinterface

// File: rtl/sum_tree_batch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 any_req
);

   localparam int IW = $clog2(N);

   // Scan from the farthest offset down so the closest one to ptr wins last.
   always_comb begin
      int idx;
      gnt_id  = '0;
      any_req = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) begin
            gnt_id  = IW'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sum_tree_batch_arbiter.sv
// Time-shares one summing tree among NUM_REQ clients, one NUM_INPUTS-word batch per grant,
// and returns each sum tagged with the owning requester id.
module sum_tree_batch_arbiter
   import sum_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int NUM_INPUTS  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int SUM_TIMEOUT = 64
) (
   input logic                     clk,
   input logic                     rst,
   sum_tree_batch_arbiter_if.slave bus
);

   localparam int SUM_W = sum_w(DATA_WIDTH, NUM_INPUTS);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(NUM_INPUTS + 1);
   localparam int TO_W  = $clog2(SUM_TIMEOUT + 1);

   state_t            state_q;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   gnt_id_q;
   logic [CNT_W-1:0]  word_cnt_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic              res_valid_q;
   logic [SUM_W-1:0]  res_sum_q;
   logic [ID_W-1:0]   res_id_q;
   logic              err_timeout_q;
   logic              err_spurious_q;

   logic [ID_W-1:0]       arb_gnt;
   logic                  arb_any;
   logic [ID_W-1:0]       rr_ptr_d;
   logic                  feeding;
   logic                  sel_valid;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  xfer;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .gnt_id  (arb_gnt),
      .any_req (arb_any)
   );

   assign rr_ptr_d  = (arb_gnt == ID_W'(NUM_REQ - 1)) ? '0 : arb_gnt + ID_W'(1);
   assign feeding   = (state_q == FEED);
   assign sel_valid = bus.req_valid[gnt_id_q];
   assign sel_data  = bus.req_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
   assign xfer      = feeding && sel_valid && bus.tree_ready;

   // Only the locked grantee ever sees the tree's ready.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign bus.req_ready[gi] = feeding && (gnt_id_q == ID_W'(gi)) && bus.tree_ready;
      end
   endgenerate

   assign bus.tree_valid   = feeding && sel_valid;
   assign bus.tree_data    = feeding ? sel_data : '0;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_sum      = res_sum_q;
   assign bus.res_id       = res_id_q;
   assign bus.err_timeout  = err_timeout_q;
   assign bus.err_spurious = err_spurious_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         rr_ptr_q       <= '0;
         gnt_id_q       <= '0;
         word_cnt_q     <= '0;
         to_cnt_q       <= '0;
         res_valid_q    <= 1'b0;
         res_sum_q      <= '0;
         res_id_q       <= '0;
         err_timeout_q  <= 1'b0;
         err_spurious_q <= 1'b0;
      end else begin
         err_timeout_q  <= 1'b0;
         err_spurious_q <= bus.tree_sum_valid && (state_q != WAIT_SUM);
         case (state_q)
            IDLE: begin
               if (arb_any) begin
                  gnt_id_q   <= arb_gnt;
                  rr_ptr_q   <= rr_ptr_d;
                  word_cnt_q <= '0;
                  state_q    <= FEED;
               end
            end
            FEED: begin
               if (xfer) begin
                  if (word_cnt_q == CNT_W'(NUM_INPUTS - 1)) begin
                     word_cnt_q <= '0;
                     to_cnt_q   <= '0;
                     state_q    <= WAIT_SUM;
                  end else begin
                     word_cnt_q <= word_cnt_q + CNT_W'(1);
                  end
               end
            end
            WAIT_SUM: begin
               if (bus.tree_sum_valid) begin
                  res_sum_q   <= bus.tree_sum;
                  res_id_q    <= gnt_id_q;
                  res_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end else if (to_cnt_q == TO_W'(SUM_TIMEOUT - 1)) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= IDLE;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            HOLD: begin
               // The tree must stay idle until this result is taken, so no grant here.
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_tree_batch_arbiter.sv
// Bench for sum_tree_batch_arbiter: behavioural tree, table-driven batches, corner sequences
// and a randomized round-robin run checked against a queue-based reference.
module tb_sum_tree_batch_arbiter;
   import sum_arb_pkg::*;

   localparam int NR = 4;
   localparam int NI = 8;
   localparam int DW = 32;
   localparam int SW = sum_w(DW, NI);
   localparam int IW = $clog2(NR);
   localparam int TO = 64;

   typedef struct {
      int            id;
      logic [DW-1:0] first;
      logic [DW-1:0] step;
      logic [SW-1:0] exp_sum;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sum_tree_batch_arbiter_if #(.NUM_REQ(NR), .NUM_INPUTS(NI), .DATA_WIDTH(DW)) bus ();

   sum_tree_batch_arbiter #(
      .NUM_REQ(NR), .NUM_INPUTS(NI), .DATA_WIDTH(DW), .SUM_TIMEOUT(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] wq [NR][$];
   int            sent [NR];
   int            fire_cnt [NR];
   int            foreign_rdy = 0;
   int            allowed_id = -1;
   int            tv_hold = 0;
   int            err_to = 0;
   int            err_sp = 0;
   bit            bubbles = 0;
   bit            withhold = 0;
   bit            stray = 0;
   bit            rmode = 0;
   logic          rr_ctl = 1'b1;
   logic [SW-1:0] rsum_q [$];
   logic [IW-1:0] rid_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Client drivers, behavioural summing tree and result monitor.
   initial begin : drv
      logic [NR-1:0] f;
      logic          tf;
      logic          hs;
      logic [DW-1:0] td;
      logic [DW-1:0] w;
      logic [SW-1:0] acc;
      logic [SW-1:0] sumv;
      int            acnt;
      int            lat;
      bit            pend;
      acc = '0; sumv = '0; acnt = 0; lat = 0; pend = 0;
      for (int r = 0; r < NR; r++) begin sent[r] = 0; fire_cnt[r] = 0; end
      bus.req_valid = '0; bus.req_data = '0; bus.tree_ready = 1'b0;
      bus.tree_sum = '0; bus.tree_sum_valid = 1'b0; bus.res_ready = 1'b0;
      forever begin
         @(negedge clk);
         f  = bus.req_valid & bus.req_ready;
         tf = bus.tree_valid && bus.tree_ready;
         td = bus.tree_data;
         hs = bus.res_valid && bus.res_ready;
         if (!rst) begin
            for (int r = 0; r < NR; r++)
               if (allowed_id >= 0 && r != allowed_id && bus.req_ready[r]) foreign_rdy++;
            if (bus.tree_valid && bus.res_valid) tv_hold++;
            if (bus.err_timeout) err_to++;
            if (bus.err_spurious) err_sp++;
            if (hs) begin
               rsum_q.push_back(bus.res_sum);
               rid_q.push_back(bus.res_id);
            end
         end
         @(posedge clk);
         #1;
         bus.tree_sum_valid = 1'b0;
         if (rst) begin
            acc = '0; acnt = 0; pend = 0;
            for (int r = 0; r < NR; r++) sent[r] = 0;
         end else begin
            for (int r = 0; r < NR; r++) begin
               if (f[r] && wq[r].size() > 0) begin
                  w = wq[r].pop_front();
                  sent[r] = (sent[r] + 1) % NI;
                  fire_cnt[r]++;
               end
            end
            if (pend) begin
               if (lat == 0) begin
                  bus.tree_sum_valid = 1'b1;
                  bus.tree_sum = sumv;
                  pend = 0;
               end else begin
                  lat--;
               end
            end
            if (tf) begin
               acc += SW'(td);
               acnt++;
               if (acnt == NI) begin
                  sumv = acc; acc = '0; acnt = 0;
                  pend = !withhold;
                  lat = int'($urandom_range(0, 3));
               end
            end
            if (stray) begin
               bus.tree_sum_valid = 1'b1;
               bus.tree_sum = SW'(35'h1234);
               stray = 0;
            end
         end
         // A client only bubbles once its batch has started, so pending clients face the arbiter.
         for (int r = 0; r < NR; r++) begin
            bus.req_valid[r] = (wq[r].size() > 0) &&
                               !(bubbles && sent[r] != 0 && $urandom_range(0, 3) == 0);
            bus.req_data[r*DW +: DW] = (wq[r].size() > 0) ? wq[r][0] : '0;
         end
         bus.tree_ready = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.res_ready  = rmode ? 1'($urandom_range(0, 1)) : rr_ctl;
      end
   end

   task automatic push_batch(input int id, input logic [DW-1:0] first, input logic [DW-1:0] step);
      for (int i = 0; i < NI; i++) wq[id].push_back(first + DW'(i) * step);
   endtask

   task automatic wait_result(output logic [SW-1:0] s, output logic [IW-1:0] id, output bit ok);
      int n = 0;
      ok = 0; s = '0; id = '0;
      while (rsum_q.size() == 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (rsum_q.size() > 0) begin
         s = rsum_q.pop_front();
         id = rid_q.pop_front();
         ok = 1;
      end else begin
         checks++; failures++;
         $display("FAIL result_timeout actual=none expected=result within 3000 cycles");
      end
   endtask

   task automatic chk_zero_outputs(input string name);
      chk({name, "_ctl"}, {59'd0, bus.tree_valid, bus.res_valid, bus.err_timeout,
          bus.err_spurious, 1'b0} | 64'(bus.req_ready) << 5, 64'd0);
      chk({name, "_sum"}, 64'(bus.res_sum), 64'd0);
      chk({name, "_id"}, 64'(bus.res_id), 64'd0);
   endtask

   initial begin : main
      vec_t          tbl [4];
      logic [SW-1:0] s;
      logic [IW-1:0] id;
      bit            ok;
      int            n;
      int            bad;
      int            snap_to;
      int            snap_sp;
      int            exp_id2 [6];
      logic [SW-1:0] exp_s2 [6];
      logic [SW-1:0] exp_q [NR][$];
      int            ptr;
      int            total;
      int            eid;

      tbl[0] = '{1, 32'd1,          32'd1,          35'd36};
      tbl[1] = '{2, 32'hFFFF_FFFF,  32'd0,          35'h7_FFFF_FFF8};
      tbl[2] = '{0, 32'd5,          32'd3,          35'd124};
      tbl[3] = '{3, 32'h8000_0000,  32'h1000_0000,  35'h5_C000_0000};
      exp_id2 = '{0, 1, 2, 3, 0, 1};
      exp_s2  = '{35'd8, 35'd16, 35'd24, 35'd32, 35'd72, 35'd80};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b0;

      // Single-requester batches.
      for (int t = 0; t < 4; t++) begin
         fire_cnt[tbl[t].id] = 0;
         foreign_rdy = 0;
         allowed_id = tbl[t].id;
         push_batch(tbl[t].id, tbl[t].first, tbl[t].step);
         wait_result(s, id, ok);
         if (ok) begin
            chk($sformatf("tbl%0d_sum", t), 64'(s), 64'(tbl[t].exp_sum));
            chk($sformatf("tbl%0d_id", t), 64'(id), 64'(tbl[t].id));
         end
         chk($sformatf("tbl%0d_xfers", t), 64'(fire_cnt[tbl[t].id]), 64'd8);
         chk($sformatf("tbl%0d_foreign_ready", t), 64'(foreign_rdy), 64'd0);
      end
      allowed_id = -1;

      // All four pending out of reset, then req0 and req1 again.
      @(negedge clk);
      rst = 1'b1;
      for (int r = 0; r < NR; r++) push_batch(r, DW'(r + 1), '0);
      push_batch(0, 32'd9, '0);
      push_batch(1, 32'd10, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_result(s, id, ok);
         if (ok) begin
            chk($sformatf("rr%0d_id", k), 64'(id), 64'(exp_id2[k]));
            chk($sformatf("rr%0d_sum", k), 64'(s), 64'(exp_s2[k]));
         end
      end

      // Result held back while req0 waits.
      rr_ctl = 1'b0;
      fire_cnt[1] = 0;
      push_batch(1, 32'd1, 32'd1);
      n = 0;
      while (fire_cnt[1] == 0 && n < 200) begin @(negedge clk); n++; end
      push_batch(0, 32'd7, '0);
      n = 0;
      while (!bus.res_valid && n < 200) begin @(negedge clk); n++; end
      chk("hold_res_valid_seen", 64'(bus.res_valid), 64'd1);
      tv_hold = 0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.res_valid !== 1'b1 || bus.res_sum !== 35'd36 || bus.res_id !== 2'd1) bad++;
      end
      chk("hold_stable_bad_cycles", 64'(bad), 64'd0);
      chk("hold_tree_valid_cycles", 64'(tv_hold), 64'd0);
      rr_ctl = 1'b1;
      n = 0;
      while (!(bus.res_valid && bus.res_ready) && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      chk("release_idle_ctl", {62'd0, bus.res_valid, |bus.req_ready}, 64'd0);
      @(negedge clk);
      chk("release_req0_ready", 64'(bus.req_ready), 64'b0001);
      wait_result(s, id, ok);
      if (ok) chk("hold_result", {27'd0, s, id}, {27'd0, 35'd36, 2'd1});
      wait_result(s, id, ok);
      if (ok) chk("after_hold_result", {27'd0, s, id}, {27'd0, 35'd56, 2'd0});

      // Tree never answers: timeout after SUM_TIMEOUT cycles of waiting.
      withhold = 1;
      snap_to = err_to;
      fire_cnt[2] = 0;
      push_batch(2, 32'd1, 32'd1);
      n = 0;
      while (fire_cnt[2] != 8 && n < 200) begin @(posedge clk); #2; n++; end
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.err_timeout || n >= 200) break;
         n++;
      end
      chk("timeout_cycle", 64'(n), 64'd64);
      @(negedge clk);
      chk("timeout_pulse_width", 64'(bus.err_timeout), 64'd0);
      chk("timeout_count", 64'(err_to - snap_to), 64'd1);
      chk("timeout_no_result", 64'(rsum_q.size()) | 64'(bus.res_valid), 64'd0);
      withhold = 0;

      // Stray tree pulse while idle.
      snap_sp = err_sp;
      stray = 1;
      repeat (5) @(negedge clk);
      chk("spurious_count", 64'(err_sp - snap_sp), 64'd1);
      chk("spurious_no_result", 64'(rsum_q.size()) | 64'(bus.res_valid), 64'd0);

      // Reset in the middle of a batch.
      fire_cnt[3] = 0;
      push_batch(3, 32'd50, 32'd1);
      n = 0;
      while (fire_cnt[3] < 5 && n < 200) begin @(negedge clk); n++; end
      chk("midrst_words_before", 64'(fire_cnt[3]), 64'd5);
      rst = 1'b1;
      #1;
      chk_zero_outputs("midrst");
      wq[3].delete();
      push_batch(3, 32'd1, 32'd1);
      fire_cnt[3] = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_result(s, id, ok);
      if (ok) chk("midrst_fresh_result", {27'd0, s, id}, {27'd0, 35'd36, 2'd3});
      chk("midrst_fresh_xfers", 64'(fire_cnt[3]), 64'd8);

      // Randomized batches with bubbles and result backpressure.
      @(negedge clk);
      rst = 1'b1;
      total = 0;
      for (int r = 0; r < NR; r++) begin
         int nb;
         nb = int'($urandom_range(1, 3));
         for (int b = 0; b < nb; b++) begin
            logic [SW-1:0] es;
            logic [DW-1:0] wv;
            es = '0;
            for (int i = 0; i < NI; i++) begin
               wv = $urandom;
               wq[r].push_back(wv);
               es += SW'(wv);
            end
            exp_q[r].push_back(es);
            total++;
         end
      end
      snap_to = err_to;
      snap_sp = err_sp;
      tv_hold = 0;
      bubbles = 1;
      rmode = 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ptr = 0;
      for (int k = 0; k < total; k++) begin
         eid = -1;
         for (int i = 0; i < NR && eid < 0; i++)
            if (exp_q[(ptr + i) % NR].size() > 0) eid = (ptr + i) % NR;
         wait_result(s, id, ok);
         if (!ok) break;
         chk($sformatf("rand%0d_id", k), 64'(id), 64'(eid));
         if (eid >= 0) begin
            chk($sformatf("rand%0d_sum", k), 64'(s), 64'(exp_q[eid].pop_front()));
            ptr = (eid + 1) % NR;
         end
      end
      chk("rand_errors", 64'(err_to - snap_to) + 64'(err_sp - snap_sp), 64'd0);
      chk("rand_tree_valid_in_hold", 64'(tv_hold), 64'd0);
      rmode = 0;
      bubbles = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=still running expected=finished within 40000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
